// File: rtl/cpu_pkg.sv
// Shared types and constants for the reduced RISC-V core: widths, ALU
// opcodes, operand-select encodings and the ID/EX pipeline record.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // ALU operation codes. Codes 13..31 are not named here; the ALU decides
  // what they produce, the pipeline only carries them.
  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_SLL_R = 5'd2,
    ALU_SLL_I = 5'd3,
    ALU_SLT   = 5'd4,
    ALU_SLTU  = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_SRL_R = 5'd7,
    ALU_SRA_R = 5'd8,
    ALU_SRL_I = 5'd9,
    ALU_SRA_I = 5'd10,
    ALU_OR    = 5'd11,
    ALU_AND   = 5'd12
  } alu_op_e;

  // SrcA select; the reserved encoding reads as zero.
  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2,
    SRC_A_RSVD = 2'd3
  } src_a_sel_e;

  typedef enum logic {
    SRC_B_RS2 = 1'b0,
    SRC_B_IMM = 1'b1
  } src_b_sel_e;

  // Everything the execute stage needs from decode, held for one cycle.
  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd;
    logic [4:0]        alu_ctrl;
    src_a_sel_e        src_a_sel;
    src_b_sel_e        src_b_sel;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } idex_t;

  // A bubble has no architectural side effects; data fields are zeroed too
  // so a reset stage and a bubbled stage look identical.
  localparam idex_t IDEX_BUBBLE = '0;

  // True when a destination register is non-zero and matches either source.
  function automatic logic rd_hits_src(input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs1,
                                       input logic [REG_AW-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-to-execute bundle: decode-side inputs, forwarding sources from the
// later stages, pipeline control, and the ALU-facing outputs.
//
// Handshake: valid_i qualifies the decode slot; the stage accepts it on a
// rising edge unless flush_i, stall_i or load_use_stall_o is high. While
// load_use_stall_o is high, decode must hold its instruction (valid_i and all
// fields) until the edge on which load_use_stall_o is low.
interface id_ex_operand_stage_if;
  import cpu_pkg::*;

  logic              valid_i;
  logic [XLEN-1:0]   pc_i;
  logic [XLEN-1:0]   rs1_data_i;
  logic [XLEN-1:0]   rs2_data_i;
  logic [XLEN-1:0]   imm_i;
  logic [REG_AW-1:0] rs1_addr_i;
  logic [REG_AW-1:0] rs2_addr_i;
  logic [REG_AW-1:0] rd_addr_i;
  logic [4:0]        alu_ctrl_i;
  logic [1:0]        src_a_sel_i;
  logic              src_b_sel_i;
  logic              reg_write_i;
  logic              mem_read_i;
  logic              mem_write_i;
  logic              stall_i;
  logic              flush_i;
  logic [REG_AW-1:0] exmem_rd_i;
  logic              exmem_reg_write_i;
  logic [XLEN-1:0]   exmem_result_i;
  logic [REG_AW-1:0] memwb_rd_i;
  logic              memwb_reg_write_i;
  logic [XLEN-1:0]   memwb_result_i;

  logic [XLEN-1:0]   SrcA_o;
  logic [XLEN-1:0]   SrcB_o;
  logic [4:0]        ALUCtrl_o;
  logic [XLEN-1:0]   store_data_o;
  logic              valid_o;
  logic              reg_write_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [REG_AW-1:0] rd_o;
  logic [XLEN-1:0]   pc_o;
  logic              load_use_stall_o;

  modport master (
    output valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i, alu_ctrl_i,
           src_a_sel_i, src_b_sel_i, reg_write_i, mem_read_i, mem_write_i,
           stall_i, flush_i,
           exmem_rd_i, exmem_reg_write_i, exmem_result_i,
           memwb_rd_i, memwb_reg_write_i, memwb_result_i,
    input  SrcA_o, SrcB_o, ALUCtrl_o, store_data_o, valid_o, reg_write_o,
           mem_read_o, mem_write_o, rd_o, pc_o, load_use_stall_o
  );

  modport slave (
    input  valid_i, pc_i, rs1_data_i, rs2_data_i, imm_i,
           rs1_addr_i, rs2_addr_i, rd_addr_i, alu_ctrl_i,
           src_a_sel_i, src_b_sel_i, reg_write_i, mem_read_i, mem_write_i,
           stall_i, flush_i,
           exmem_rd_i, exmem_reg_write_i, exmem_result_i,
           memwb_rd_i, memwb_reg_write_i, memwb_result_i,
    output SrcA_o, SrcB_o, ALUCtrl_o, store_data_o, valid_o, reg_write_o,
           mem_read_o, mem_write_o, rd_o, pc_o, load_use_stall_o
  );

endinterface

// File: rtl/operand_forward.sv
// Per-operand bypass mux: the youngest in-flight writer of a register wins,
// and x0 is never bypassed because it always reads as zero.
module operand_forward
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic              exmem_reg_write_i,
  input  logic [XLEN-1:0]   exmem_result_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic              memwb_reg_write_i,
  input  logic [XLEN-1:0]   memwb_result_i,
  output logic [XLEN-1:0]   fwd_data_o
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_reg_write_i && (exmem_rd_i == rs_addr_i) && (rs_addr_i != '0);
  assign hit_memwb = memwb_reg_write_i && (memwb_rd_i == rs_addr_i) && (rs_addr_i != '0);

  // EX/MEM holds the newer value, so it takes precedence over MEM/WB.
  always_comb begin
    fwd_data_o = rf_data_i;
    if (hit_exmem) begin
      fwd_data_o = exmem_result_i;
    end else if (hit_memwb) begin
      fwd_data_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with execute-side forwarding and load-use
// hazard detection. Operands leave this stage ready for the ALU.
module id_ex_operand_stage
  import cpu_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  id_ex_operand_stage_if.slave bus
);

  idex_t             idex_q;
  idex_t             idex_d;
  logic              load_use;
  logic [XLEN-1:0]   fwd_rs1;
  logic [XLEN-1:0]   fwd_rs2;

  // A load in this stage whose result the decode instruction needs cannot be
  // bypassed in time; ask decode to hold for one cycle. A flush kills both.
  always_comb begin
    load_use = 1'b0;
    if (!bus.flush_i && bus.valid_i && idex_q.valid && idex_q.mem_read) begin
      load_use = rd_hits_src(idex_q.rd, bus.rs1_addr_i, bus.rs2_addr_i);
    end
  end

  // Next contents: flush empties, stall holds, hazard bubbles, else capture.
  always_comb begin
    idex_d = idex_q;
    if (bus.flush_i) begin
      idex_d = IDEX_BUBBLE;
    end else if (bus.stall_i) begin
      idex_d = idex_q;
    end else if (load_use) begin
      idex_d = IDEX_BUBBLE;
    end else begin
      idex_d.valid     = bus.valid_i;
      idex_d.pc        = bus.pc_i;
      idex_d.rs1_data  = bus.rs1_data_i;
      idex_d.rs2_data  = bus.rs2_data_i;
      idex_d.imm       = bus.imm_i;
      idex_d.rs1_addr  = bus.rs1_addr_i;
      idex_d.rs2_addr  = bus.rs2_addr_i;
      idex_d.rd        = bus.rd_addr_i;
      idex_d.alu_ctrl  = bus.alu_ctrl_i;
      idex_d.src_a_sel = src_a_sel_e'(bus.src_a_sel_i);
      idex_d.src_b_sel = src_b_sel_e'(bus.src_b_sel_i);
      idex_d.reg_write = bus.reg_write_i;
      idex_d.mem_read  = bus.mem_read_i;
      idex_d.mem_write = bus.mem_write_i;
    end
  end

  // Pipeline register; reset clears every field immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idex_q <= IDEX_BUBBLE;
    end else begin
      idex_q <= idex_d;
    end
  end

  operand_forward u_fwd_rs1 (
    .rs_addr_i         (idex_q.rs1_addr),
    .rf_data_i         (idex_q.rs1_data),
    .exmem_rd_i        (bus.exmem_rd_i),
    .exmem_reg_write_i (bus.exmem_reg_write_i),
    .exmem_result_i    (bus.exmem_result_i),
    .memwb_rd_i        (bus.memwb_rd_i),
    .memwb_reg_write_i (bus.memwb_reg_write_i),
    .memwb_result_i    (bus.memwb_result_i),
    .fwd_data_o        (fwd_rs1)
  );

  operand_forward u_fwd_rs2 (
    .rs_addr_i         (idex_q.rs2_addr),
    .rf_data_i         (idex_q.rs2_data),
    .exmem_rd_i        (bus.exmem_rd_i),
    .exmem_reg_write_i (bus.exmem_reg_write_i),
    .exmem_result_i    (bus.exmem_result_i),
    .memwb_rd_i        (bus.memwb_rd_i),
    .memwb_reg_write_i (bus.memwb_reg_write_i),
    .memwb_result_i    (bus.memwb_result_i),
    .fwd_data_o        (fwd_rs2)
  );

  // ALU operand muxes; the reserved SrcA encoding behaves like zero.
  always_comb begin
    bus.SrcA_o = '0;
    case (idex_q.src_a_sel)
      SRC_A_RS1: bus.SrcA_o = fwd_rs1;
      SRC_A_PC:  bus.SrcA_o = idex_q.pc;
      default:   bus.SrcA_o = '0;
    endcase
    bus.SrcB_o = (idex_q.src_b_sel == SRC_B_IMM) ? idex_q.imm : fwd_rs2;
  end

  assign bus.store_data_o     = fwd_rs2;
  assign bus.ALUCtrl_o        = idex_q.alu_ctrl;
  assign bus.valid_o          = idex_q.valid;
  assign bus.reg_write_o      = idex_q.reg_write;
  assign bus.mem_read_o       = idex_q.mem_read;
  assign bus.mem_write_o      = idex_q.mem_write;
  assign bus.rd_o             = idex_q.rd;
  assign bus.pc_o             = idex_q.pc;
  assign bus.load_use_stall_o = load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for the ID/EX operand stage: directed scenarios followed by random
// traffic, all checked against a behavioural model of the stage contents.
module tb_id_ex_operand_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  id_ex_operand_stage_if bus ();

  id_ex_operand_stage dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model state ----------------
  logic        m_valid, m_rw, m_mr, m_mw, m_bsel;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1a, m_rs2a, m_rd, m_alu;
  logic [1:0]  m_asel;

  task automatic model_clear();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_bsel = 0;
    m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
    m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_alu = 0; m_asel = 0;
  endtask

  // Value an instruction reading register r would see given in-flight writers.
  function automatic logic [31:0] exp_fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return rf;
    if (bus.exmem_reg_write_i && bus.exmem_rd_i == r) return bus.exmem_result_i;
    if (bus.memwb_reg_write_i && bus.memwb_rd_i == r) return bus.memwb_result_i;
    return rf;
  endfunction

  function automatic logic [31:0] exp_src_a();
    if (m_asel == 2'd0) return exp_fwd(m_rs1a, m_rs1d);
    if (m_asel == 2'd1) return m_pc;
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_src_b();
    return m_bsel ? m_imm : exp_fwd(m_rs2a, m_rs2d);
  endfunction

  function automatic logic exp_lus();
    if (bus.flush_i || !bus.valid_i || !m_valid || !m_mr || m_rd == 0) return 1'b0;
    return (m_rd == bus.rs1_addr_i) || (m_rd == bus.rs2_addr_i);
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_model();
    check_eq("valid_o",     64'(bus.valid_o),          64'(m_valid));
    check_eq("reg_write_o", 64'(bus.reg_write_o),      64'(m_rw));
    check_eq("mem_read_o",  64'(bus.mem_read_o),       64'(m_mr));
    check_eq("mem_write_o", 64'(bus.mem_write_o),      64'(m_mw));
    check_eq("rd_o",        64'(bus.rd_o),             64'(m_rd));
    check_eq("pc_o",        64'(bus.pc_o),             64'(m_pc));
    check_eq("ALUCtrl_o",   64'(bus.ALUCtrl_o),        64'(m_alu));
    check_eq("SrcA_o",      64'(bus.SrcA_o),           64'(exp_src_a()));
    check_eq("SrcB_o",      64'(bus.SrcB_o),           64'(exp_src_b()));
    check_eq("store_data",  64'(bus.store_data_o),     64'(exp_fwd(m_rs2a, m_rs2d)));
    check_eq("load_use",    64'(bus.load_use_stall_o), 64'(exp_lus()));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(bus.valid_o), 0);
    check_eq({tag, "_rw"},    64'(bus.reg_write_o), 0);
    check_eq({tag, "_mr"},    64'(bus.mem_read_o), 0);
    check_eq({tag, "_mw"},    64'(bus.mem_write_o), 0);
    check_eq({tag, "_rd"},    64'(bus.rd_o), 0);
    check_eq({tag, "_pc"},    64'(bus.pc_o), 0);
    check_eq({tag, "_alu"},   64'(bus.ALUCtrl_o), 0);
    check_eq({tag, "_srca"},  64'(bus.SrcA_o), 0);
    check_eq({tag, "_srcb"},  64'(bus.SrcB_o), 0);
    check_eq({tag, "_st"},    64'(bus.store_data_o), 0);
    check_eq({tag, "_lus"},   64'(bus.load_use_stall_o), 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_decode(input logic v, input logic [31:0] pc,
                            input logic [4:0] rs1a, input logic [31:0] rs1d,
                            input logic [4:0] rs2a, input logic [31:0] rs2d,
                            input logic [31:0] imm, input logic [4:0] rd,
                            input logic [4:0] alu, input logic [1:0] asel,
                            input logic bsel, input logic rw, input logic mr,
                            input logic mw);
    bus.valid_i = v; bus.pc_i = pc;
    bus.rs1_addr_i = rs1a; bus.rs1_data_i = rs1d;
    bus.rs2_addr_i = rs2a; bus.rs2_data_i = rs2d;
    bus.imm_i = imm; bus.rd_addr_i = rd; bus.alu_ctrl_i = alu;
    bus.src_a_sel_i = asel; bus.src_b_sel_i = bsel;
    bus.reg_write_i = rw; bus.mem_read_i = mr; bus.mem_write_i = mw;
  endtask

  task automatic set_idle();
    set_decode(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    bus.exmem_reg_write_i = ew; bus.exmem_rd_i = erd; bus.exmem_result_i = eres;
    bus.memwb_reg_write_i = mw; bus.memwb_rd_i = mrd; bus.memwb_result_i = mres;
  endtask

  task automatic drive_random();
    set_decode($urandom_range(0, 1), $urandom, 5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    set_fwd($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
    bus.flush_i = ($urandom_range(0, 9) == 0);
    bus.stall_i = ($urandom_range(0, 5) == 0);
  endtask

  // Sample on the falling edge, well away from the capturing edge.
  task automatic sample();
    @(negedge clk);
    check_model();
  endtask

  // Apply the stage's update rule to the model, then cross the clock edge.
  task automatic advance();
    logic lus;
    lus = exp_lus();
    if (bus.flush_i || (!bus.stall_i && lus)) begin
      model_clear();
    end else if (!bus.stall_i) begin
      m_valid = bus.valid_i; m_pc = bus.pc_i;
      m_rs1a = bus.rs1_addr_i; m_rs1d = bus.rs1_data_i;
      m_rs2a = bus.rs2_addr_i; m_rs2d = bus.rs2_data_i;
      m_imm = bus.imm_i; m_rd = bus.rd_addr_i; m_alu = bus.alu_ctrl_i;
      m_asel = bus.src_a_sel_i; m_bsel = bus.src_b_sel_i;
      m_rw = bus.reg_write_i; m_mr = bus.mem_read_i; m_mw = bus.mem_write_i;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  // Assert reset between edges and confirm outputs clear before any edge.
  task automatic reset_mid(input string tag);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    check_all_zero(tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    rst_n = 1'b0;
    set_idle();
    set_fwd(0, 0, 0, 0, 0, 0);
    bus.flush_i = 0;
    bus.stall_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD x?, x5, x6 with no writers in flight.
    set_decode(1, 32'h100, 5, 32'h10, 6, 32'h20, 32'h4, 9, 0, 0, 0, 1, 0, 0);
    step();
    set_idle();
    sample();
    check_eq("add_srca",  64'(bus.SrcA_o), 64'h10);
    check_eq("add_srcb",  64'(bus.SrcB_o), 64'h20);
    check_eq("add_alu",   64'(bus.ALUCtrl_o), 0);
    check_eq("add_valid", 64'(bus.valid_o), 1);
    advance();

    // Both later stages write x5: EX/MEM wins, then MEM/WB once EX/MEM drops.
    set_decode(1, 32'h104, 5, 32'h10, 6, 32'h20, 0, 10, 1, 0, 0, 1, 0, 0);
    step();
    set_idle();
    set_fwd(1, 5, 32'hAAAA, 1, 5, 32'hBBBB);
    bus.stall_i = 1;
    sample();
    check_eq("fwd_exmem", 64'(bus.SrcA_o), 64'hAAAA);
    advance();
    bus.exmem_reg_write_i = 0;
    sample();
    check_eq("fwd_memwb", 64'(bus.SrcA_o), 64'hBBBB);
    advance();
    bus.stall_i = 0;

    // x0 is never forwarded.
    set_decode(1, 32'h108, 0, 0, 0, 0, 0, 11, 0, 0, 0, 1, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    step();
    set_idle();
    set_fwd(1, 0, 32'hFFFF, 1, 0, 32'hFFFF);
    sample();
    check_eq("fwd_x0", 64'(bus.SrcA_o), 0);
    advance();
    set_fwd(0, 0, 0, 0, 0, 0);

    // Load x7, then a consumer of x7 via rs2: one bubble, then capture.
    set_decode(1, 32'h10C, 1, 32'h40, 2, 0, 32'h8, 7, 0, 0, 1, 1, 1, 0);
    step();
    set_decode(1, 32'h110, 3, 32'h1, 7, 32'h2, 0, 8, 1, 0, 0, 1, 0, 0);
    sample();
    check_eq("lu_req", 64'(bus.load_use_stall_o), 1);
    advance();
    sample();
    check_eq("lu_bub_valid", 64'(bus.valid_o), 0);
    check_eq("lu_bub_rw",    64'(bus.reg_write_o), 0);
    check_eq("lu_bub_lus",   64'(bus.load_use_stall_o), 0);
    advance();
    set_idle();
    sample();
    check_eq("lu_cap_valid", 64'(bus.valid_o), 1);
    check_eq("lu_cap_rd",    64'(bus.rd_o), 8);
    check_eq("lu_cap_lus",   64'(bus.load_use_stall_o), 0);
    advance();

    // Load-use under a downstream hold: no bubble, request stays up.
    set_decode(1, 32'h114, 4, 32'h5, 0, 0, 0, 12, 0, 0, 0, 1, 1, 0);
    step();
    set_decode(1, 32'h118, 12, 32'h3, 1, 32'h4, 0, 13, 0, 0, 0, 1, 0, 0);
    bus.stall_i = 1;
    repeat (2) begin
      sample();
      check_eq("hold_lus",   64'(bus.load_use_stall_o), 1);
      check_eq("hold_valid", 64'(bus.valid_o), 1);
      check_eq("hold_rd",    64'(bus.rd_o), 12);
      advance();
    end
    bus.stall_i = 0;
    step();
    step();
    set_idle();

    // Flush beats stall.
    set_decode(1, 32'h200, 2, 32'h77, 3, 32'h88, 0, 14, 6, 0, 0, 1, 0, 0);
    step();
    set_idle();
    bus.flush_i = 1;
    bus.stall_i = 1;
    step();
    bus.flush_i = 0;
    bus.stall_i = 0;
    sample();
    check_eq("flush_valid", 64'(bus.valid_o), 0);
    advance();

    // Stall alone for three cycles keeps the captured instruction.
    set_decode(1, 32'h300, 2, 32'h1234, 3, 32'h5678, 32'h9, 15, 12, 0, 1, 1, 0, 0);
    step();
    drive_random();
    bus.flush_i = 0;
    bus.stall_i = 1;
    bus.valid_i = 0;
    set_fwd(0, 0, 0, 0, 0, 0);
    repeat (3) begin
      sample();
      check_eq("stall_srca", 64'(bus.SrcA_o), 64'h1234);
      check_eq("stall_srcb", 64'(bus.SrcB_o), 64'h9);
      check_eq("stall_pc",   64'(bus.pc_o), 64'h300);
      check_eq("stall_alu",  64'(bus.ALUCtrl_o), 12);
      advance();
      drive_random();
      bus.flush_i = 0;
      bus.stall_i = 1;
      bus.valid_i = 0;
      set_fwd(0, 0, 0, 0, 0, 0);
    end
    bus.stall_i = 0;

    // Reset with a valid instruction in the stage.
    set_decode(1, 32'h400, 5, 32'hABC, 6, 32'hDEF, 0, 9, 3, 1, 0, 1, 1, 1);
    step();
    set_idle();
    reset_mid("rst_mid");

    // Random traffic with the occasional reset.
    for (int i = 0; i < 400; i++) begin
      drive_random();
      if (i % 97 == 96) begin
        reset_mid("rst_rand");
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
